// File: rtl/kgp_div_pkg.sv
// rtl/kgp_div_pkg.sv - shared types and constants for the KGP-RISC iterative divider
package kgp_div_pkg;

  localparam int DIV_WIDTH = 32;

  // Quotient reported when the divisor is zero
  localparam logic [DIV_WIDTH-1:0] DIV0_QUOTIENT = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } div_state_t;

endpackage

// File: rtl/div_addsub_stage.sv
// rtl/div_addsub_stage.sv - shared add/subtract stage for the partial remainder
module div_addsub_stage #(
  parameter int W = 33
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] y
);

  assign y = sub ? (a - b) : (a + b);

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - non-restoring iterative divider, one quotient bit per cycle
// Optional signed operation: define DIV_SIGNED_EN.
module seq_divider
  import kgp_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  div_state_t       state;
  logic [WIDTH:0]   p;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   p_shift;
  logic [WIDTH:0]   as_a;
  logic [WIDTH:0]   as_b;
  logic [WIDTH:0]   as_y;
  logic             as_sub;
  logic [WIDTH-1:0] r_fix;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] q_out;
  logic [WIDTH-1:0] r_out;

  assign p_shift = {p[WIDTH-1:0], q[WIDTH-1]};
  assign as_b    = {1'b0, d};

  // RUN steps the shifted remainder; FIX reuses the stage for the final P+D correction
  always_comb begin
    as_a   = p;
    as_sub = 1'b0;
    if (state == ST_RUN) begin
      as_a   = p_shift;
      as_sub = ~p[WIDTH];
    end
  end

  div_addsub_stage #(.W(WIDTH + 1)) u_addsub (
    .a   (as_a),
    .b   (as_b),
    .sub (as_sub),
    .y   (as_y)
  );

  assign r_fix = p[WIDTH] ? as_y[WIDTH-1:0] : p[WIDTH-1:0];

`ifdef DIV_SIGNED_EN
  logic neg_q;
  logic neg_r;

  assign a_mag = dividend[WIDTH-1] ? (-dividend) : dividend;
  assign b_mag = divisor[WIDTH-1]  ? (-divisor)  : divisor;
  assign q_out = neg_q ? (-q) : q;
  assign r_out = neg_r ? (-r_fix) : r_fix;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (state == ST_IDLE && start) begin
      neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      neg_r <= dividend[WIDTH-1];
    end
  end
`else
  assign a_mag = dividend;
  assign b_mag = divisor;
  assign q_out = q;
  assign r_out = r_fix;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      p           <= '0;
      q           <= '0;
      d           <= '0;
      cnt         <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            busy <= 1'b1;
            d    <= b_mag;
            if (divisor == '0) begin
              quotient    <= WIDTH'(DIV0_QUOTIENT);
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              state       <= ST_DONE;
            end else begin
              div_by_zero <= 1'b0;
              p           <= '0;
              q           <= a_mag;
              cnt         <= '0;
              state       <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          p   <= as_y;
          q   <= {q[WIDTH-2:0], ~as_y[WIDTH]};
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            cnt   <= '0;
            state <= ST_FIX;
          end
        end
        ST_FIX: begin
          quotient  <= q_out;
          remainder <= r_out;
          state     <= ST_DONE;
        end
        ST_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - randomized self-checking bench for seq_divider against an arithmetic model
module tb_seq_divider;
  import kgp_div_pkg::*;

  localparam int W = DIV_WIDTH;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_checks = 0;
  int n_errors = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected results straight from the arithmetic definition
  function automatic void model_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] mq, output logic [W-1:0] mr,
                                    output logic mz);
    logic signed [W-1:0] sa;
    logic signed [W-1:0] sb;
    sa = a;
    sb = b;
    mz = (b == '0);
    if (mz) begin
      mq = '1;
      mr = a;
    end else begin
`ifdef DIV_SIGNED_EN
      if (a == {1'b1, {(W-1){1'b0}}} && b == '1) begin
        mq = a;
        mr = '0;
      end else begin
        mq = sa / sb;
        mr = sa % sb;
      end
`else
      mq = a / b;
      mr = a % b;
`endif
    end
  endfunction

  // Cycle-level model: accept when idle, fixed latency, one-cycle done
  logic         m_busy = 1'b0;
  logic         m_done = 1'b0;
  int           m_left = 0;
  logic [W-1:0] m_q = '0;
  logic [W-1:0] m_r = '0;
  logic         m_z = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_left = 0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
        end
      end else if (start) begin
        m_busy = 1'b1;
        m_left = (divisor == '0) ? 1 : W + 2;
        model_div(dividend, divisor, m_q, m_r, m_z);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      if (m_done) begin
        chk("quotient", quotient, m_q);
        chk("remainder", remainder, m_r);
        chk("div_by_zero", div_by_zero, m_z);
      end
    end
  end

  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!done && lat < 200);
    if (!done) begin
      n_checks++;
      n_errors++;
      $display("FAIL timeout: no done within %0d cycles", lat);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int           lat;
    int           busy_low;
    logic [W-1:0] tq;
    logic [W-1:0] tr;
    logic         tz;
    logic [W-1:0] a;
    logic [W-1:0] b;

    model_div(32'd100, 32'd7, tq, tr, tz);
    chk("model_100_7_q", tq, 32'd14);
    chk("model_100_7_r", tr, 32'd2);
    model_div(32'd5, 32'd0, tq, tr, tz);
    chk("model_div0_q", tq, 32'hFFFF_FFFF);
    chk("model_div0_z", tz, 1'b1);

    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_q", quotient, 32'd0);
    chk("reset_r", remainder, 32'd0);
    chk("reset_z", div_by_zero, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_div(32'd100, 32'd7, lat);
    chk("u100_7_q", quotient, 32'd14);
    chk("u100_7_r", remainder, 32'd2);
    chk("u100_7_z", div_by_zero, 1'b0);
    chk("u100_7_latency", lat, 34);

    run_div(32'd5, 32'd0, lat);
    chk("div0_q", quotient, 32'hFFFF_FFFF);
    chk("div0_r", remainder, 32'd5);
    chk("div0_z", div_by_zero, 1'b1);
    chk("div0_latency", lat, 1);

`ifdef DIV_SIGNED_EN
    run_div(32'hFFFF_FFF9, 32'd2, lat);
    chk("s_m7_2_q", quotient, 32'hFFFF_FFFD);
    chk("s_m7_2_r", remainder, 32'hFFFF_FFFF);
    run_div(32'h8000_0000, 32'hFFFF_FFFF, lat);
    chk("s_ovf_q", quotient, 32'h8000_0000);
    chk("s_ovf_r", remainder, 32'd0);
`else
    run_div(32'hFFFF_FFF9, 32'd2, lat);
    chk("u_big_2_q", quotient, 32'h7FFF_FFFC);
    chk("u_big_2_r", remainder, 32'd1);
    chk("div0_flag_cleared", div_by_zero, 1'b0);
`endif

    // Start pulse while busy must be ignored
    dividend = 32'd100;
    divisor  = 32'd7;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    lat      = 0;
    busy_low = 0;
    do begin
      if (lat == 10) begin
        dividend = 32'd9;
        divisor  = 32'd3;
        start    = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
      if (!busy && !done) busy_low++;
    end while (!done && lat < 200);
    start = 1'b0;
    chk("ignored_start_q", quotient, 32'd14);
    chk("ignored_start_r", remainder, 32'd2);
    chk("ignored_start_latency", lat, 34);
    chk("busy_unbroken", busy_low, 0);
    run_div(32'd9, 32'd3, lat);
    chk("later_9_3_q", quotient, 32'd3);
    chk("later_9_3_r", remainder, 32'd0);

    // Asynchronous reset mid-RUN
    dividend = 32'd100;
    divisor  = 32'd7;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrun_reset_busy", busy, 1'b0);
    chk("midrun_reset_done", done, 1'b0);
    chk("midrun_reset_q", quotient, 32'd0);
    chk("midrun_reset_r", remainder, 32'd0);
    chk("midrun_reset_z", div_by_zero, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_div(32'hFFFF_FFFF, 32'd1, lat);
    chk("after_reset_q", quotient, 32'hFFFF_FFFF);
    chk("after_reset_r", remainder, 32'd0);
    chk("after_reset_latency", lat, 34);

    // Random operations, some back-to-back, with stray starts while busy
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      if ($urandom_range(0, 3) == 0) a = a >> $urandom_range(0, 31);
      case ($urandom_range(0, 9))
        0:       b = '0;
        1:       b = 32'd1;
        2:       b = '1;
        3:       b = $urandom_range(1, 15);
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(posedge clk);
      #1;
      lat = 0;
      do begin
        start = ($urandom_range(0, 7) == 0);
        if (start) begin
          dividend = $urandom;
          divisor  = $urandom;
        end
        @(posedge clk);
        #1;
        lat++;
      end while (!done && lat < 200);
      start = 1'b0;
      if (!done) begin
        n_checks++;
        n_errors++;
        $display("FAIL random_timeout: op %0d no done", i);
      end
      if ($urandom_range(0, 1) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
      #0;
    end

    repeat (3) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
